// File: rtl/atm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : atm_pkg
// Purpose  : Shared types and constants for the ATM session controller.
// Revision : 1.0 - initial release
// ============================================================================
package atm_pkg;

  localparam int PIN_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int PIN_W      = 16;
  localparam int ACC_ADDR_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_SCAN  = 3'd1,
    ST_PIN_ENTRY  = 3'd2,
    ST_LOOKUP     = 3'd3,
    ST_COMPARE    = 3'd4,
    ST_AUTHORIZED = 3'd5,
    ST_EJECT      = 3'd6,
    ST_RETAIN     = 3'd7
  } state_e;

  // A keypad code is a usable PIN digit only if it is decimal.
  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return (d <= 4'd9);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pin_entry_buf.sv
`default_nettype none
// ============================================================================
// Module   : pin_entry_buf
// Purpose  : Collects keypad digits into a PIN, MSD first, with digit count,
//            decimal filtering and clear.
// Revision : 1.0 - initial release
// ============================================================================
module pin_entry_buf
  import atm_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable_i,
  input  logic               clear_i,
  input  logic [DIGIT_W-1:0] digit_i,
  input  logic               digit_valid_i,
  output logic               accept_o,
  output logic               last_o,
  output logic [PIN_W-1:0]   pin_value,
  output logic               pin_full
);

  localparam int            CW     = $clog2(PIN_DIGITS + 1);
  localparam logic [CW-1:0] C_FULL = CW'(PIN_DIGITS);
  localparam logic [CW-1:0] C_LAST = CW'(PIN_DIGITS - 1);

  logic [CW-1:0]    count_q, count_d;
  logic [PIN_W-1:0] value_q, value_d;

  // Clear beats a digit in the same cycle; a full buffer takes no more digits.
  assign accept_o  = enable_i & digit_valid_i & is_bcd(digit_i) & ~clear_i &
                     (count_q != C_FULL);
  assign last_o    = accept_o & (count_q == C_LAST);
  assign pin_value = value_q;
  assign pin_full  = (count_q == C_FULL);

  // Next value of the shift register and the digit counter.
  always_comb begin
    count_d = count_q;
    value_d = value_q;
    if (clear_i) begin
      count_d = '0;
      value_d = '0;
    end else if (accept_o) begin
      count_d = count_q + 1'b1;
      value_d = {value_q[PIN_W-DIGIT_W-1:0], digit_i};
    end
  end

  // Digit storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      value_q <= '0;
    end else begin
      count_q <= count_d;
      value_q <= value_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/atm_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : atm_session_ctrl
// Purpose  : Card/PIN session sequencer: scan, PIN entry, account lookup,
//            compare, grant, eject or retain.
// Revision : 1.0 - initial release
// ============================================================================
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Insert_Card,
  input  logic                  card_scanned,
  input  logic [ACC_ADDR_W-1:0] acc_addr,
  input  logic [DIGIT_W-1:0]    pin_digit,
  input  logic                  pin_digit_valid,
  input  logic                  pin_clear,
  input  logic                  mem_ack,
  input  logic [PIN_W-1:0]      mem_pin,
  input  logic                  session_end,
  output logic                  mem_req,
  output logic [ACC_ADDR_W-1:0] mem_addr,
  output logic                  auth_ok,
  output logic                  pin_error,
  output logic [2:0]            tries_left,
  output logic                  card_eject,
  output logic                  card_retain,
  output logic [2:0]            state_dbg
);

  localparam int            TW          = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] C_TMAX      = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    C_MAX_TRIES = 3'(MAX_TRIES);

  state_e                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [2:0]            tries_q;
  logic [ACC_ADDR_W-1:0] mem_addr_q;
  logic [PIN_W-1:0]      stored_q;
  logic                  pin_error_q;

  logic [PIN_W-1:0]      pin_value;
  logic                  pin_full;
  logic                  w_accept, w_pin_last, w_buf_clear;
  logic                  w_abort, w_timeout, w_match, w_last_try, w_fail;

  assign w_abort    = ~Insert_Card & (state_q != ST_IDLE) &
                      (state_q != ST_EJECT) & (state_q != ST_RETAIN);
  assign w_timeout  = (timer_q == C_TMAX);
  assign w_match    = pin_full & (pin_value == stored_q);
  assign w_last_try = ((tries_q + 3'd1) >= C_MAX_TRIES);
  assign w_fail     = (state_q == ST_COMPARE) & ~w_abort & ~w_match;
  assign w_buf_clear = (state_q == ST_IDLE) | (state_q == ST_COMPARE) |
                       ((state_q == ST_PIN_ENTRY) & pin_clear);

  pin_entry_buf u_pin_buf (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (state_q == ST_PIN_ENTRY),
    .clear_i       (w_buf_clear),
    .digit_i       (pin_digit),
    .digit_valid_i (pin_digit_valid),
    .accept_o      (w_accept),
    .last_o        (w_pin_last),
    .pin_value     (pin_value),
    .pin_full      (pin_full)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; card removal overrides every other event.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (Insert_Card) state_d = ST_WAIT_SCAN;
      ST_WAIT_SCAN:  if (card_scanned) state_d = ST_PIN_ENTRY;
      ST_PIN_ENTRY: begin
        if (w_timeout)       state_d = ST_EJECT;
        else if (w_pin_last) state_d = ST_LOOKUP;
      end
      ST_LOOKUP:     if (mem_ack) state_d = ST_COMPARE;
      ST_COMPARE: begin
        if (w_match)         state_d = ST_AUTHORIZED;
        else if (w_last_try) state_d = ST_RETAIN;
        else                 state_d = ST_PIN_ENTRY;
      end
      ST_AUTHORIZED: if (session_end || w_timeout) state_d = ST_EJECT;
      ST_EJECT,
      ST_RETAIN:     if (!Insert_Card) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
    if (w_abort) state_d = ST_IDLE;
  end

  // Inactivity timer: restarts on state entry and on keypad activity, saturates.
  always_comb begin
    timer_d = timer_q;
    if ((state_d != state_q) ||
        ((state_q == ST_PIN_ENTRY) && (w_accept || pin_clear))) begin
      timer_d = '0;
    end else if (!w_timeout) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Session datapath: address latch, stored PIN, attempt counter, error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_q     <= '0;
      tries_q     <= '0;
      mem_addr_q  <= '0;
      stored_q    <= '0;
      pin_error_q <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      pin_error_q <= w_fail;
      if ((state_q == ST_WAIT_SCAN) && (state_d == ST_PIN_ENTRY)) mem_addr_q <= acc_addr;
      if ((state_q == ST_LOOKUP) && (state_d == ST_COMPARE))      stored_q   <= mem_pin;
      if (state_q == ST_IDLE)  tries_q <= '0;
      else if (w_fail)         tries_q <= tries_q + 3'd1;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    mem_req     = (state_q == ST_LOOKUP);
    auth_ok     = (state_q == ST_AUTHORIZED);
    card_eject  = (state_q == ST_EJECT);
    card_retain = (state_q == ST_RETAIN);
    state_dbg   = state_q;
    mem_addr    = mem_addr_q;
    pin_error   = pin_error_q;
    tries_left  = C_MAX_TRIES - tries_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_atm_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_atm_session_ctrl
// Purpose  : Directed scenarios plus randomized traffic against a session
//            model for atm_session_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_atm_session_ctrl;
  import atm_pkg::*;

  localparam int MAX_TRIES = 3;
  localparam int T         = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Insert_Card = 1'b0, card_scanned = 1'b0;
  logic [4:0]  acc_addr = '0;
  logic [3:0]  pin_digit = '0;
  logic        pin_digit_valid = 1'b0, pin_clear = 1'b0;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_pin = '0;
  logic        session_end = 1'b0;
  logic        mem_req, auth_ok, pin_error, card_eject, card_retain;
  logic [4:0]  mem_addr;
  logic [2:0]  tries_left, state_dbg;

  int n_chk = 0;
  int n_pass = 0;

  atm_session_ctrl #(.MAX_TRIES(MAX_TRIES), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .Insert_Card(Insert_Card), .card_scanned(card_scanned),
    .acc_addr(acc_addr), .pin_digit(pin_digit), .pin_digit_valid(pin_digit_valid),
    .pin_clear(pin_clear), .mem_ack(mem_ack), .mem_pin(mem_pin), .session_end(session_end),
    .mem_req(mem_req), .mem_addr(mem_addr), .auth_ok(auth_ok), .pin_error(pin_error),
    .tries_left(tries_left), .card_eject(card_eject), .card_retain(card_retain),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  // ---------------- session model ----------------
  state_e     m_st = ST_IDLE;
  logic [3:0] m_digits[$];
  int         m_timer = 0;
  int         m_tries = 0;
  logic [4:0] m_addr = '0;
  logic [15:0] m_stored = '0;
  logic       m_err = 1'b0;
  bit         started = 1'b0;

  function automatic logic [15:0] entered_value();
    int v = 0;
    foreach (m_digits[i]) v = v * 16 + int'(m_digits[i]);
    return 16'(v);
  endfunction

  always @(posedge clk) begin
    state_e nxt;
    bit     reload;
    if (!rst_n) begin
      m_st = ST_IDLE; m_digits.delete(); m_timer = 0; m_tries = 0;
      m_addr = '0; m_stored = '0; m_err = 1'b0;
    end else begin
      nxt = m_st; reload = 1'b0; m_err = 1'b0;
      if (!Insert_Card && !(m_st inside {ST_IDLE, ST_EJECT, ST_RETAIN})) begin
        nxt = ST_IDLE;
      end else begin
        case (m_st)
          ST_IDLE: begin
            m_tries = 0; m_digits.delete();
            if (Insert_Card) nxt = ST_WAIT_SCAN;
          end
          ST_WAIT_SCAN: if (card_scanned) begin m_addr = acc_addr; nxt = ST_PIN_ENTRY; end
          ST_PIN_ENTRY: begin
            if (m_timer == T - 1) nxt = ST_EJECT;
            else if (pin_clear) begin m_digits.delete(); reload = 1'b1; end
            else if (pin_digit_valid && pin_digit <= 4'd9 && m_digits.size() < 4) begin
              m_digits.push_back(pin_digit); reload = 1'b1;
              if (m_digits.size() == 4) nxt = ST_LOOKUP;
            end
          end
          ST_LOOKUP: if (mem_ack) begin m_stored = mem_pin; nxt = ST_COMPARE; end
          ST_COMPARE: begin
            if (m_digits.size() == 4 && entered_value() == m_stored) nxt = ST_AUTHORIZED;
            else begin
              m_tries++; m_err = 1'b1;
              nxt = (m_tries >= MAX_TRIES) ? ST_RETAIN : ST_PIN_ENTRY;
            end
            m_digits.delete();
          end
          ST_AUTHORIZED: if (session_end || m_timer == T - 1) nxt = ST_EJECT;
          default: if (!Insert_Card) nxt = ST_IDLE;
        endcase
      end
      if (nxt != m_st || reload) m_timer = 0;
      else if (m_timer < T - 1)  m_timer++;
      m_st = nxt;
    end
    started = 1'b1;
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("cmp_state",  16'(state_dbg),   16'(m_st));
      chk("cmp_req",    16'(mem_req),     16'(m_st == ST_LOOKUP));
      chk("cmp_addr",   16'(mem_addr),    16'(m_addr));
      chk("cmp_auth",   16'(auth_ok),     16'(m_st == ST_AUTHORIZED));
      chk("cmp_err",    16'(pin_error),   16'(m_err));
      chk("cmp_tries",  16'(tries_left),  16'(3'(MAX_TRIES - m_tries)));
      chk("cmp_eject",  16'(card_eject),  16'(m_st == ST_EJECT));
      chk("cmp_retain", 16'(card_retain), 16'(m_st == ST_RETAIN));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic key(input logic [3:0] d);
    pin_digit = d; pin_digit_valid = 1'b1; tick(); pin_digit_valid = 1'b0;
  endtask

  task automatic key4(input logic [15:0] v);
    for (int i = 3; i >= 0; i--) key(4'((v >> (4 * i)) & 16'hF));
  endtask

  task automatic start_session(input logic [4:0] a);
    Insert_Card = 1'b1; tick();
    card_scanned = 1'b1; acc_addr = a; tick(); card_scanned = 1'b0;
  endtask

  task automatic ack(input logic [15:0] p);
    mem_ack = 1'b1; mem_pin = p; tick(); mem_ack = 1'b0;
  endtask

  task automatic leave();
    Insert_Card = 1'b0; tick(2);
  endtask

  initial begin
    tick(2); rst_n = 1'b1;
    chk("rst_state", 16'(state_dbg), 16'd0);
    chk("rst_tries", 16'(tries_left), 16'd3);
    chk("rst_addr",  16'(mem_addr), 16'd0);

    // Correct PIN.
    start_session(5'd9);
    chk("t1_addr", 16'(mem_addr), 16'd9);
    key4(16'h1234);
    chk("t1_req", 16'(mem_req), 16'd1);
    tick();
    ack(16'h1234);
    chk("t1_cmp_state", 16'(state_dbg), 16'd4);
    chk("t1_auth_early", 16'(auth_ok), 16'd0);
    tick();
    chk("t1_auth", 16'(auth_ok), 16'd1);
    session_end = 1'b1; tick(); session_end = 1'b0;
    chk("t1_eject", 16'(card_eject), 16'd1);
    tick();
    chk("t1_eject_hold", 16'(card_eject), 16'd1);
    Insert_Card = 1'b0; tick();
    chk("t1_idle", 16'(state_dbg), 16'd0);
    tick();

    // Retention after three failures.
    start_session(5'd3);
    for (int i = 0; i < 3; i++) begin
      key4(16'h1111);
      ack(16'h1234);
      tick();
      chk("t2_err", 16'(pin_error), 16'd1);
      chk("t2_tries", 16'(tries_left), 16'(2 - i));
      if (i == 2) chk("t2_retain", 16'(card_retain), 16'd1);
      tick();
      chk("t2_err_pulse", 16'(pin_error), 16'd0);
    end
    chk("t2_retain_hold", 16'(card_retain), 16'd1);
    Insert_Card = 1'b0; tick();
    chk("t2_idle", 16'(state_dbg), 16'd0);
    tick();
    chk("t2_tries_reload", 16'(tries_left), 16'd3);

    // Invalid digit and clear.
    start_session(5'd17);
    key(4'd1); key(4'hA); key(4'd2);
    pin_clear = 1'b1; key(4'd3); pin_clear = 1'b0;
    key(4'd4); key(4'd5); key(4'd6);
    chk("t3_no_req", 16'(mem_req), 16'd0);
    key(4'd7);
    chk("t3_req", 16'(mem_req), 16'd1);
    ack(16'h4567);
    tick();
    chk("t3_auth", 16'(auth_ok), 16'd1);
    Insert_Card = 1'b0; tick();
    chk("t3_abort_auth", 16'(state_dbg), 16'd0);
    tick();

    // Timeout in PIN_ENTRY.
    start_session(5'd1);
    key(4'd1); key(4'd2);
    tick(T - 1);
    chk("t4_not_yet", 16'(card_eject), 16'd0);
    chk("t4_no_req", 16'(mem_req), 16'd0);
    tick();
    chk("t4_eject", 16'(card_eject), 16'd1);
    leave();

    // Abort during LOOKUP.
    start_session(5'd2);
    key4(16'h1234);
    chk("t5_req", 16'(mem_req), 16'd1);
    Insert_Card = 1'b0; tick();
    chk("t5_idle", 16'(state_dbg), 16'd0);
    ack(16'h1234);
    chk("t5_auth", 16'(auth_ok), 16'd0);
    chk("t5_err", 16'(pin_error), 16'd0);
    tick();
    chk("t5_still_idle", 16'(state_dbg), 16'd0);

    // Reset mid-session.
    start_session(5'd30);
    key4(16'h9999); ack(16'h1234); tick(2);
    key4(16'h1234); ack(16'h1234); tick();
    chk("t6_auth", 16'(auth_ok), 16'd1);
    chk("t6_tries", 16'(tries_left), 16'd2);
    rst_n = 1'b0; tick();
    chk("t6_state", 16'(state_dbg), 16'd0);
    chk("t6_auth_rst", 16'(auth_ok), 16'd0);
    chk("t6_tries_rst", 16'(tries_left), 16'd3);
    chk("t6_addr_rst", 16'(mem_addr), 16'd0);
    rst_n = 1'b1; Insert_Card = 1'b0; tick();

    // Randomized traffic.
    begin
      int digit_pct = 40;
      for (int c = 0; c < 6000; c++) begin
        if (c % 200 == 0) digit_pct = ($urandom_range(0, 1) == 0) ? 40 : 4;
        if (!rst_n) rst_n = 1'b1;
        else if ($urandom_range(0, 999) < 3) rst_n = 1'b0;
        if (Insert_Card) Insert_Card = ($urandom_range(0, 99) >= 2);
        else             Insert_Card = ($urandom_range(0, 99) < 30);
        card_scanned    = ($urandom_range(0, 99) < 30);
        acc_addr        = 5'($urandom);
        pin_digit_valid = ($urandom_range(0, 99) < digit_pct);
        pin_digit       = 4'($urandom);
        pin_clear       = ($urandom_range(0, 99) < 3);
        mem_ack         = ($urandom_range(0, 99) < 30);
        mem_pin         = ($urandom_range(0, 1) == 0) ? entered_value() : 16'($urandom);
        session_end     = ($urandom_range(0, 99) < 5);
        tick();
      end
    end

    rst_n = 1'b1; Insert_Card = 1'b0; card_scanned = 1'b0; pin_digit_valid = 1'b0;
    pin_clear = 1'b0; mem_ack = 1'b0; session_end = 1'b0;
    tick(3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/atm_session_ctrl.md
# atm_session_ctrl

Sequences one ATM customer session around the card swiper: it waits for a scanned card, collects a 4-digit PIN from the keypad, fetches the stored PIN for the scanned account address from account memory over a req/ack handshake, and compares the two. On a correct PIN it grants the session. On failures it counts attempts, retains the card after `MAX_TRIES`, and ejects the card on timeout or when the session ends. It sits between the card swiper / keypad front end and the transaction datapath.

## Interface
Parameters:
- `MAX_TRIES`, 3: wrong-PIN attempts before the card is retained; legal range 1..7.
- `TIMEOUT_CYCLES`, 1000: idle cycles allowed in PIN_ENTRY or AUTHORIZED before the card is ejected.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock; all logic is clocked on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `Insert_Card`  in  1  card present in the slot.
- `card_scanned`  in  1  swiper has valid account data.
- `acc_addr`  in  5  account memory address from the swiper.
- `pin_digit`  in  4  BCD keypad digit.
- `pin_digit_valid`  in  1  one-cycle strobe qualifying `pin_digit`.
- `pin_clear`  in  1  discard the digits entered so far.
- `mem_ack`  in  1  account memory response; `mem_pin` is valid in the same cycle.
- `mem_pin`  in  16  stored PIN, 4 BCD digits, most significant digit first.
- `session_end`  in  1  transaction datapath has finished.
- `mem_req`  out  1  lookup request; held high until `mem_ack`.
- `mem_addr`  out  5  latched `acc_addr`.
- `auth_ok`  out  1  high throughout AUTHORIZED.
- `pin_error`  out  1  one-cycle pulse on a PIN mismatch.
- `tries_left`  out  3  `MAX_TRIES` minus the number of failures so far.
- `card_eject`  out  1  high throughout EJECT.
- `card_retain`  out  1  high throughout RETAIN.
- `state_dbg`  out  3  current state encoding.

## Operation
States: IDLE, WAIT_SCAN, PIN_ENTRY, LOOKUP, COMPARE, AUTHORIZED, EJECT, RETAIN.

- **IDLE**: move to WAIT_SCAN when `Insert_Card`=1. Clear the tries counter and the digit count.
- **WAIT_SCAN**: when `card_scanned`=1, latch `acc_addr` into `mem_addr` and go to PIN_ENTRY.
- **PIN_ENTRY**:
  - A valid digit ≤ 9 shifts into a 16-bit PIN register, most significant digit first, and increments the digit count (0..4).
  - Digits > 9 are ignored and do not reset the timeout counter.
  - When a strobe raises the count to 4, go to LOOKUP.
  - `pin_clear` zeroes the count and wins over a digit arriving in the same cycle.
  - The timeout counter reloads on state entry, on each accepted digit and on `pin_clear`. Expiry goes to EJECT.
- **LOOKUP**: `mem_req`=1. On `mem_ack`, capture `mem_pin` and go to COMPARE.
- **COMPARE**: one cycle, entered on every attempt.
  - Match: go to AUTHORIZED.
  - Mismatch: increment tries and pulse `pin_error`. Go to RETAIN if tries reaches `MAX_TRIES`; otherwise return to PIN_ENTRY with the digit count cleared.
- **AUTHORIZED**: `auth_ok`=1. `session_end` or timeout goes to EJECT. The timeout counter reloads only on state entry.
- **EJECT / RETAIN**: hold the output high until `Insert_Card`=0, then go to IDLE.
- **Abort**: `Insert_Card`=0 in any state other than IDLE, EJECT or RETAIN returns to IDLE next cycle.
  - Abort has priority over every other event, including timeout, `mem_ack` and `session_end`.
  - A `mem_ack` arriving after an abort is ignored.

## Timing
- Reset values: state IDLE, all pulse and level outputs 0, `mem_addr`=0, `tries_left`=`MAX_TRIES`, PIN register 0, counters 0.
- All outputs are registered or decoded from the registered state; there are no combinational input-to-output paths.
- Latency:
  - 4th digit accepted in cycle N → `mem_req` high in cycle N+1.
  - `mem_ack` in cycle M → COMPARE in M+1 → `auth_ok` or `pin_error` in M+2.
- `pin_error` is high for exactly one cycle per mismatch.
- `tries_left` updates in the same cycle as `pin_error`.
- Timeout fires when the counter reaches `TIMEOUT_CYCLES`-1, i.e. exactly `TIMEOUT_CYCLES` cycles after the last reload. The next state is EJECT in the following cycle.
- Counter width is `$clog2(TIMEOUT_CYCLES)`. The counter saturates and never wraps.
- Reset asserted mid-session returns to IDLE on the next edge; any outstanding `mem_req` drops immediately.

## Structure
- Shared package `atm_pkg`:
  - state enum typedef (3-bit);
  - `PIN_DIGITS`=4, `PIN_W`=16, `ACC_ADDR_W`=5.
- Sub-module `pin_entry_buf`: digit shift register, digit counter, BCD validity check and clear. Outputs `pin_value[15:0]` and `pin_full`.
- The FSM, tries counter and timeout counter stay in the top level.

## Test plan
- **Correct PIN**: card inserted, scan with `acc_addr`=5'd9, digits 1,2,3,4, `mem_ack` with `mem_pin`=16'h1234 → `mem_addr`=9; `auth_ok`=1 two cycles after the ack; `session_end` → `card_eject`=1 until `Insert_Card`=0, then IDLE.
- **Retention after three failures**: three attempts of 1,1,1,1 against `mem_pin`=16'h1234 → three `pin_error` pulses; `tries_left` goes 2,1,0; `card_retain`=1 after the third.
- **Invalid digit and clear**: digits 1, 4'hA, 2, then `pin_clear`+3 in the same cycle, then 4,5,6,7 → compared value is 16'h4567; `mem_req` asserts only after the 7.
- **Timeout in PIN_ENTRY**: 2 digits, then idle for `TIMEOUT_CYCLES` cycles → `card_eject`=1 exactly one cycle after expiry; `mem_req` never asserted.
- **Abort during LOOKUP**: `Insert_Card`=0 while `mem_req`=1, then `mem_ack` one cycle later → IDLE; `auth_ok` stays 0; no `pin_error`.
- **Reset mid-session**: `rst_n`=0 in AUTHORIZED → next edge all outputs at reset values; `tries_left`=3.
